// File: rtl/ibex_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ibex_mem_arb_pkg
// Shared types for the Ibex instruction/data memory-port arbiter.
//   arb_src_e   : which requester owns a transaction
//   arb_state_e : arbiter address-phase state
//   INSTR_BE    : byte enables driven for instruction fetches
// ----------------------------------------------------------------------------
package ibex_mem_arb_pkg;

   typedef enum logic {SRC_INSTR, SRC_DATA} arb_src_e;

   typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D} arb_state_e;

   localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/ibex_mem_arb_src_fifo.sv
// ----------------------------------------------------------------------------
// ibex_mem_arb_src_fifo
// In-order record of which requester issued each outstanding transaction.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : enqueue a source (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   full_o/empty_o: occupancy flags
//   head_o        : source of the oldest outstanding transaction
// ----------------------------------------------------------------------------
module ibex_mem_arb_src_fifo
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     push_i,
   input  arb_src_e data_i,
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output arb_src_e head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   arb_src_e        r_mem [Depth];
   logic [PtrW-1:0] r_wptr;
   logic [PtrW-1:0] r_rptr;
   logic [CntW-1:0] r_count;
   logic            w_push;
   logic            w_pop;

   assign full_o  = (r_count == CntW'(Depth));
   assign empty_o = (r_count == '0);
   assign head_o  = r_mem[r_rptr];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) r_mem[i] <= SRC_INSTR;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
         end
         if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      end
   end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_mem_arbiter
// Shares one OBI memory port between Ibex instruction fetch and LSU.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ARB_IDLE   | no address phase held; selection is free each cycle
// ARB_LOCK_I | fetch address phase issued but not granted; fetch is forced
// ARB_LOCK_D | LSU address phase issued but not granted; LSU is forced
//
// Ports:
//   clk_i, rst_ni       : clock, async active-low reset
//   instr_* / data_*    : requester OBI interfaces (req/gnt/addr/rvalid/rdata/err)
//   mem_*               : shared downstream OBI port
//   proto_err_o         : sticky flag, response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module ibex_mem_arbiter
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          DataPriority   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        proto_err_o
);

   arb_state_e r_state;
   arb_state_e w_state_d;
   arb_src_e   r_rr_ptr;
   arb_src_e   w_sel;
   arb_src_e   w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_hs;
   logic       w_resp;
   logic       r_proto_err;

   // A lock only holds while its owner keeps requesting; if the owner drops
   // req the arbiter behaves as idle in that same cycle so the grant can never
   // land on a requester that is not asking.
   always_comb begin
      w_sel = SRC_INSTR;
      if (r_state == ARB_LOCK_I && instr_req_i) begin
         w_sel = SRC_INSTR;
      end else if (r_state == ARB_LOCK_D && data_req_i) begin
         w_sel = SRC_DATA;
      end else if (instr_req_i && data_req_i) begin
         if (DataPriority) w_sel = SRC_DATA;
         else              w_sel = (r_rr_ptr == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
      end else if (data_req_i) begin
         w_sel = SRC_DATA;
      end
   end

   // No bypass: a pop in this cycle does not free a slot for this cycle.
   assign mem_req_o = (instr_req_i | data_req_i) & ~w_full;
   assign w_hs      = mem_req_o & mem_gnt_i;

   assign mem_addr_o  = (w_sel == SRC_DATA) ? data_addr_i  : instr_addr_i;
   assign mem_we_o    = (w_sel == SRC_DATA) ? data_we_i    : 1'b0;
   assign mem_be_o    = (w_sel == SRC_DATA) ? data_be_i    : INSTR_BE;
   assign mem_wdata_o = (w_sel == SRC_DATA) ? data_wdata_i : 32'h0;

   assign instr_gnt_o = w_hs & (w_sel == SRC_INSTR);
   assign data_gnt_o  = w_hs & (w_sel == SRC_DATA);

   always_comb begin
      w_state_d = ARB_IDLE;
      if (mem_req_o && !mem_gnt_i) begin
         w_state_d = (w_sel == SRC_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ARB_IDLE;
         r_rr_ptr    <= SRC_INSTR;
         r_proto_err <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_hs) r_rr_ptr <= w_sel;
         if (mem_rvalid_i && w_empty) r_proto_err <= 1'b1;
      end
   end

   assign proto_err_o = r_proto_err;

   assign w_resp = mem_rvalid_i & ~w_empty;

   ibex_mem_arb_src_fifo #(
      .Depth (MaxOutstanding)
   ) u_src_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_hs),
      .data_i  (w_sel),
      .pop_i   (w_resp),
      .full_o  (w_full),
      .empty_o (w_empty),
      .head_o  (w_head)
   );

   assign instr_rvalid_o = w_resp & (w_head == SRC_INSTR);
   assign data_rvalid_o  = w_resp & (w_head == SRC_DATA);
   assign instr_err_o    = mem_err_i & instr_rvalid_o;
   assign data_err_o     = mem_err_i & data_rvalid_o;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;

   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o, proto_err_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;

   logic        rr_instr_gnt_o, rr_instr_rvalid_o, rr_instr_err_o;
   logic [31:0] rr_instr_rdata_o;
   logic        rr_data_gnt_o, rr_data_rvalid_o, rr_data_err_o;
   logic [31:0] rr_data_rdata_o;
   logic        rr_mem_req_o, rr_mem_we_o, rr_proto_err_o;
   logic [3:0]  rr_mem_be_o;
   logic [31:0] rr_mem_addr_o, rr_mem_wdata_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .proto_err_o(proto_err_o)
   );

   ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_gnt_o(rr_instr_gnt_o), .instr_rvalid_o(rr_instr_rvalid_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(rr_instr_rdata_o), .instr_err_o(rr_instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(rr_data_gnt_o), .data_rvalid_o(rr_data_rvalid_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(rr_data_rdata_o), .data_err_o(rr_data_err_o),
      .mem_req_o(rr_mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_we_o(rr_mem_we_o), .mem_be_o(rr_mem_be_o), .mem_addr_o(rr_mem_addr_o),
      .mem_wdata_o(rr_mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .proto_err_o(rr_proto_err_o)
   );

   task automatic idle_inputs();
      instr_req_i  = 1'b0;
      instr_addr_i = 32'h0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      mem_err_i    = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked 2
   // units later, well before the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
      n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b want 00", {instr_gnt_o, data_gnt_o}); end
      n_vec++; if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o} !== 4'b0) begin n_err++; $display("FAIL reset_rsp got %b want 0000", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}); end
      n_vec++; if ({proto_err_o, rr_proto_err_o, rr_mem_req_o} !== 3'b000) begin n_err++; $display("FAIL reset_proto got %b want 000", {proto_err_o, rr_proto_err_o, rr_mem_req_o}); end
      tick();
   endtask

   task automatic test_single_fetch();
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
      #2;
      n_vec++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin n_err++; $display("FAIL fetch_gnt got i=%b d=%b want i=1 d=0", instr_gnt_o, data_gnt_o); end
      n_vec++; if (mem_be_o !== 4'hF || mem_addr_o !== 32'h80 || mem_we_o !== 1'b0) begin n_err++; $display("FAIL fetch_addr got be=%h addr=%h we=%b want be=f addr=80 we=0", mem_be_o, mem_addr_o, mem_we_o); end
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
      #2;
      n_vec++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin n_err++; $display("FAIL fetch_rvalid got i=%b d=%b want i=1 d=0", instr_rvalid_o, data_rvalid_o); end
      n_vec++; if (instr_rdata_o !== 32'h13) begin n_err++; $display("FAIL fetch_rdata got %h want 00000013", instr_rdata_o); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_conflict();
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h84;
      data_req_i = 1'b1; data_addr_i = 32'h1000; data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hA5A5_0001;
      mem_gnt_i = 1'b1;
      #2;
      n_vec++; if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin n_err++; $display("FAIL conflict_first got i=%b d=%b want i=0 d=1", instr_gnt_o, data_gnt_o); end
      n_vec++; if (mem_addr_o !== 32'h1000 || mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL conflict_addr got addr=%h we=%b be=%h wd=%h", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
      tick();
      data_req_i = 1'b0;
      #2;
      n_vec++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h84 || mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL conflict_second got gnt=%b addr=%h wd=%h want 1 84 0", instr_gnt_o, mem_addr_o, mem_wdata_o); end
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
      #2;
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_err++; $display("FAIL conflict_rsp1 got i/d=%b want 01", {instr_rvalid_o, data_rvalid_o}); end
      tick();
      #2;
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL conflict_rsp2 got i/d=%b want 10", {instr_rvalid_o, data_rvalid_o}); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      int last_src;
      int win;
      do_reset();
      last_src = 0;   // pointer starts at instr, so data has the first turn
      for (int k = 0; k < 4; k++) begin
         instr_req_i = 1'b1; instr_addr_i = 32'h100 + 32'(4 * k);
         data_req_i = 1'b1; data_addr_i = 32'h2000 + 32'(4 * k); data_we_i = 1'b0; data_be_i = 4'hF;
         mem_gnt_i = 1'b1; mem_rvalid_i = (k > 0);
         win = 1 - last_src;
         #2;
         n_vec++; if ({rr_instr_gnt_o, rr_data_gnt_o} !== {win == 0, win == 1}) begin n_err++; $display("FAIL rr_turn%0d got i/d=%b want %b", k, {rr_instr_gnt_o, rr_data_gnt_o}, {win == 0, win == 1}); end
         n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL prio_turn%0d got data_gnt=%b want 1", k, data_gnt_o); end
         last_src = win;
         tick();
      end
      idle_inputs();
      mem_rvalid_i = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_lock_full_err();
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h200;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin data_req_i = 1'b1; data_addr_i = 32'h1000; data_we_i = 1'b0; data_be_i = 4'hF; end
         #2;
         n_vec++; if (mem_addr_o !== 32'h200 || instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1) begin n_err++; $display("FAIL lock_hold%0d got addr=%h gi=%b gd=%b req=%b", c, mem_addr_o, instr_gnt_o, data_gnt_o, mem_req_o); end
         tick();
      end
      mem_gnt_i = 1'b1;
      #2;
      n_vec++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_addr_o !== 32'h200) begin n_err++; $display("FAIL lock_grant got gi=%b gd=%b addr=%h", instr_gnt_o, data_gnt_o, mem_addr_o); end
      tick();
      instr_req_i = 1'b0;
      #2;
      n_vec++; if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h1000) begin n_err++; $display("FAIL lock_after got gd=%b addr=%h", data_gnt_o, mem_addr_o); end
      tick();
      // two outstanding (I then D): queue is full
      data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h300;
      #2;
      n_vec++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin n_err++; $display("FAIL full_block got req=%b gnt=%b want 0 0", mem_req_o, instr_gnt_o); end
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
      #2;
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL full_nobypass got req=%b want 0", mem_req_o); end
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL order_rsp1 got i/d=%b want 10", {instr_rvalid_o, data_rvalid_o}); end
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      n_vec++; if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h300) begin n_err++; $display("FAIL full_release got req=%b gnt=%b addr=%h", mem_req_o, instr_gnt_o, mem_addr_o); end
      tick();
      instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
      #2;
      n_vec++; if ({data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o} !== 4'b1100) begin n_err++; $display("FAIL err_route got drv/derr/irv/ierr=%b want 1100", {data_rvalid_o, data_err_o, instr_rvalid_o, instr_err_o}); end
      tick();
      mem_err_i = 1'b0;
      #2;
      n_vec++; if ({instr_rvalid_o, instr_err_o, data_rvalid_o} !== 3'b100) begin n_err++; $display("FAIL order_rsp3 got irv/ierr/drv=%b want 100", {instr_rvalid_o, instr_err_o, data_rvalid_o}); end
      tick();
      idle_inputs();
      #2;
      n_vec++; if (proto_err_o !== 1'b0) begin n_err++; $display("FAIL proto_clean got %b want 0", proto_err_o); end
      tick();
   endtask

   task automatic test_reset_stale();
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b1;
      tick();
      instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h44;
      tick();
      idle_inputs();
      #1;
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      mem_rvalid_i = 1'b1;
      #1;
      n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL stale_rvalid got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      n_vec++; if (proto_err_o !== 1'b1) begin n_err++; $display("FAIL stale_proto got %b want 1", proto_err_o); end
      tick();
      tick();
      #2;
      n_vec++; if (proto_err_o !== 1'b1) begin n_err++; $display("FAIL stale_sticky got %b want 1", proto_err_o); end
      tick();
   endtask

   // Reference: a queue of issuing sources in order, plus the requester whose
   // address phase is waiting for a grant. Data wins any open conflict.
   task automatic test_random();
      int q[$];
      int held;
      int sel;
      int head;
      logic exp_req, pend_i, pend_d, granted;
      do_reset();
      held = -1; pend_i = 1'b0; pend_d = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pend_i) begin
            instr_req_i  = ($urandom_range(0, 2) != 0);
            instr_addr_i = {$urandom} & 32'hFFFF_FFFC;
         end
         if (!pend_d) begin
            data_req_i   = ($urandom_range(0, 2) != 0);
            data_addr_i  = $urandom;
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = 4'($urandom_range(1, 15));
            data_wdata_i = $urandom;
         end
         mem_gnt_i    = ($urandom_range(0, 2) != 0);
         mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_rdata_i  = $urandom;
         mem_err_i    = ($urandom_range(0, 3) == 0);

         exp_req = (instr_req_i || data_req_i) && (q.size() < 2);
         if (held == 0 && instr_req_i)     sel = 0;
         else if (held == 1 && data_req_i) sel = 1;
         else if (data_req_i)              sel = 1;
         else                              sel = 0;
         granted = exp_req && mem_gnt_i;
         head = (q.size() > 0) ? q[0] : -1;
         #2;
         n_vec++; if (mem_req_o !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d got %b want %b", cyc, mem_req_o, exp_req); end
         n_vec++; if ({instr_gnt_o, data_gnt_o} !== {granted && sel == 0, granted && sel == 1}) begin n_err++; $display("FAIL rnd_gnt c%0d got i/d=%b want %b", cyc, {instr_gnt_o, data_gnt_o}, {granted && sel == 0, granted && sel == 1}); end
         if (exp_req) begin
            n_vec++; if (mem_addr_o !== (sel == 1 ? data_addr_i : instr_addr_i)) begin n_err++; $display("FAIL rnd_addr c%0d got %h want %h", cyc, mem_addr_o, (sel == 1 ? data_addr_i : instr_addr_i)); end
            n_vec++; if ({mem_we_o, mem_be_o} !== (sel == 1 ? {data_we_i, data_be_i} : 5'b0_1111)) begin n_err++; $display("FAIL rnd_we_be c%0d got %b want %b", cyc, {mem_we_o, mem_be_o}, (sel == 1 ? {data_we_i, data_be_i} : 5'b0_1111)); end
         end
         n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== {mem_rvalid_i && head == 0, mem_rvalid_i && head == 1}) begin n_err++; $display("FAIL rnd_rvalid c%0d got i/d=%b want %b", cyc, {instr_rvalid_o, data_rvalid_o}, {mem_rvalid_i && head == 0, mem_rvalid_i && head == 1}); end
         n_vec++; if ({instr_err_o, data_err_o} !== {mem_err_i && mem_rvalid_i && head == 0, mem_err_i && mem_rvalid_i && head == 1}) begin n_err++; $display("FAIL rnd_err c%0d got i/d=%b", cyc, {instr_err_o, data_err_o}); end
         n_vec++; if (data_rdata_o !== mem_rdata_i || instr_rdata_o !== mem_rdata_i) begin n_err++; $display("FAIL rnd_rdata c%0d got %h/%h want %h", cyc, instr_rdata_o, data_rdata_o, mem_rdata_i); end

         if (mem_rvalid_i) void'(q.pop_front());
         if (granted) begin
            q.push_back(sel);
            held = -1;
         end else if (exp_req) begin
            held = sel;
         end else begin
            held = -1;
         end
         pend_i = instr_req_i && !(granted && sel == 0);
         pend_d = data_req_i && !(granted && sel == 1);
         tick();
      end
      idle_inputs();
      #2;
      n_vec++; if (proto_err_o !== 1'b0) begin n_err++; $display("FAIL rnd_proto got %b want 0", proto_err_o); end
      tick();
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      test_reset();
      test_single_fetch();
      test_conflict();
      test_round_robin();
      test_lock_full_err();
      test_reset_stale();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
